// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two clients (scan-out, CPU) and the RAM macro.
// master = clients plus RAM side, slave = arbiter side.
interface vram_port_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output hcount, vcount, disp_req, disp_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_valid, disp_data, cpu_ack, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  hcount, vcount, disp_req, disp_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_valid, disp_data, cpu_ack, cpu_rdata,
    output mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads take every slot they ask for, CPU accesses fill the rest.
// Define VRAM_BLANK_ONLY_EN to restrict CPU grants to horizontal/vertical blanking.
module vram_port_arbiter #(
  parameter int HWIDTH = 640,
  parameter int VWIDTH = 480,
  parameter int AW     = 19,
  parameter int DW     = 8
) (
  input logic                clk,
  input logic                rst,
  vram_port_arbiter_if.slave bus
);

`ifdef VRAM_BLANK_ONLY_EN
  localparam bit BLANK_ONLY = 1'b1;
`else
  localparam bit BLANK_ONLY = 1'b0;
`endif

  localparam logic [9:0] H_LIMIT = 10'(HWIDTH);
  localparam logic [9:0] V_LIMIT = 10'(VWIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CPU_WAIT,
    CPU_ACK
  } state_t;

  state_t        state, state_nxt;
  logic          in_blank;
  logic          cpu_allowed;
  logic          cpu_grant;

  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;

  logic          disp_p1, disp_p2;
  logic          disp_valid_q;
  logic [DW-1:0] disp_data_q;

  logic          cpu_rd_q;
  logic          cpu_ack_q;
  logic [DW-1:0] cpu_rdata_q;

  assign in_blank    = (bus.hcount >= H_LIMIT) || (bus.vcount >= V_LIMIT);
  assign cpu_allowed = !BLANK_ONLY || in_blank;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cpu_grant = 1'b0;
    case (state)
      IDLE: begin
        // The ack pulse is registered and lands while already back in IDLE; a
        // request still held on that cycle belongs to the access just finished.
        if (!bus.disp_req && bus.cpu_req && cpu_allowed && !cpu_ack_q) begin
          cpu_grant = 1'b1;
          state_nxt = CPU_WAIT;
        end
      end
      CPU_WAIT: state_nxt = CPU_ACK;
      CPU_ACK:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slot decision: display first, then a granted CPU access, else an idle slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_rd_q    <= 1'b0;
    end else if (bus.disp_req) begin
      mem_addr_q <= bus.disp_addr;
      mem_we_q   <= 1'b0;
    end else if (cpu_grant) begin
      mem_addr_q  <= bus.cpu_addr;
      mem_we_q    <= bus.cpu_we;
      mem_wdata_q <= bus.cpu_wdata;
      cpu_rd_q    <= !bus.cpu_we;
    end else begin
      mem_we_q <= 1'b0;
    end
  end

  // Display pipeline: issue, RAM sample, capture -- one result per cycle, in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_p1      <= 1'b0;
      disp_p2      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      disp_p1      <= bus.disp_req;
      disp_p2      <= disp_p1;
      disp_valid_q <= disp_p2;
      if (disp_p2) disp_data_q <= bus.mem_rdata;
    end
  end

  // CPU completion: RAM output for the granted address is present during CPU_ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ack_q <= (state == CPU_ACK);
      if (state == CPU_ACK && cpu_rd_q) cpu_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;

endmodule
